nes_rom_loader: RTL and testbench

- Producer side of the SDRAM channel-0 loader interface: the loader_addr_mem / loader_write_mem / loader_write_data_mem / loader_busy / downloading signals that the NES top level muxes into ch0.
- Accepts 32-bit big-endian words from the APF bridge during a ROM download and buffers them in a small FIFO.
- Strips and captures the 16-byte iNES header, then writes PRG/CHR payload bytes one at a time into SDRAM.
- Paces every write against the channel busy flag.

---
 rtl/nes_rom_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_nes_rom_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_rom_loader.sv
// nes_rom_loader
//   Producer side of the SDRAM channel-0 loader path. It takes 32-bit
//   big-endian words from the APF bridge during a ROM download and buffers
//   them in a small FIFO. The words are split into bytes, most significant
//   byte first. The first 16 stream bytes (the iNES header) can be captured
//   into a register instead of being written. Every other byte is written
//   to SDRAM, one strobe at a time, and each write waits for the channel
//   busy flag to be low.
//
// Ports
//   clk_85_9              SDRAM-domain clock; all logic runs on its rising edge
//   reset_n               asynchronous active-low reset
//   dl_start / dl_end     one-cycle pulses that open and close a download
//   bridge_wr/bridge_data incoming stream word; [31:24] is first in stream order
//   bridge_ready          FIFO can accept a word this cycle
//   mem_busy              SDRAM ch0 busy
//   downloading           download session active
//   loader_busy           FIFO non-empty or a byte still in flight
//   loader_addr_mem       byte address of the current payload write
//   loader_write_mem      one-cycle write strobe
//   loader_write_data_mem byte to write, valid with the strobe
//   header                captured header; stream byte 0 at [7:0]
//   header_valid          header bytes 0..3 are 4E 45 53 1A
//   overrun               sticky: a word was dropped because the FIFO was full

module nes_rom_loader #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STRIP_HEADER = 1
) (
    input  logic         clk_85_9,
    input  logic         reset_n,
    input  logic         dl_start,
    input  logic         dl_end,
    input  logic         bridge_wr,
    input  logic [31:0]  bridge_data,
    output logic         bridge_ready,
    input  logic         mem_busy,
    output logic         downloading,
    output logic         loader_busy,
    output logic [21:0]  loader_addr_mem,
    output logic         loader_write_mem,
    output logic [7:0]   loader_write_data_mem,
    output logic [127:0] header,
    output logic         header_valid,
    output logic         overrun
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // iNES magic "NES\x1A" as it lands in header[31:0] (byte 0 in the low lane)
    localparam logic [31:0] InesMagic = 32'h1A53454E;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StByte,
        StWrite,
        StGap
    } state_e;

    state_e         state_q;

    logic [31:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic [31:0]    shifter_q;
    logic [2:0]     byte_idx_q;   // bytes of the current word already consumed
    logic [4:0]     byte_cnt_q;   // stream byte counter, saturates at 16
    logic [127:0]   header_q;
    logic           header_valid_q;
    logic           overrun_q;
    logic [21:0]    addr_q;
    logic           write_q;
    logic [7:0]     wdata_q;
    logic           downloading_q;
    logic           end_pending_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic hdr_byte;

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // A word arriving alongside dl_start belongs to no session and is dropped.
    assign push = bridge_wr & downloading_q & ~fifo_full & ~dl_start;
    assign pop  = (state_q == StFetch) & ~fifo_empty & ~dl_start;

    assign hdr_byte = (STRIP_HEADER != 0) && (byte_cnt_q < 5'd16);

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_85_9) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bridge_data;
        end
    end

    always_ff @(posedge clk_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            shifter_q      <= '0;
            byte_idx_q     <= '0;
            byte_cnt_q     <= '0;
            header_q       <= '0;
            header_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            addr_q         <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            downloading_q  <= 1'b0;
            end_pending_q  <= 1'b0;
        end else if (dl_start) begin
            // A new session flushes everything, even mid-payload.
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            shifter_q      <= '0;
            byte_idx_q     <= '0;
            byte_cnt_q     <= '0;
            header_q       <= '0;
            header_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            addr_q         <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            downloading_q  <= 1'b1;
            end_pending_q  <= 1'b0;
        end else begin
            write_q <= 1'b0;

            // Becomes valid one cycle after header byte 3 has been stored.
            header_valid_q <= (byte_cnt_q >= 5'd4) && (header_q[31:0] == InesMagic);

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase

            if (bridge_wr && downloading_q && fifo_full) begin
                overrun_q <= 1'b1;
            end
            if (dl_end && downloading_q) begin
                end_pending_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (downloading_q) begin
                        state_q <= StFetch;
                    end
                end

                StFetch: begin
                    if (!fifo_empty) begin
                        shifter_q  <= fifo_mem_q[rd_ptr_q];
                        byte_idx_q <= '0;
                        state_q    <= StByte;
                    end else if (end_pending_q) begin
                        // Host is done and everything it sent has been written.
                        downloading_q <= 1'b0;
                        end_pending_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end

                StByte: begin
                    shifter_q  <= {shifter_q[23:0], 8'h00};
                    byte_idx_q <= byte_idx_q + 3'd1;
                    if (byte_cnt_q < 5'd16) begin
                        byte_cnt_q <= byte_cnt_q + 5'd1;
                    end
                    if (hdr_byte) begin
                        header_q[{byte_cnt_q[3:0], 3'b000} +: 8] <= shifter_q[31:24];
                        state_q <= (byte_idx_q == 3'd3) ? StFetch : StByte;
                    end else begin
                        wdata_q <= shifter_q[31:24];
                        state_q <= StWrite;
                    end
                end

                StWrite: begin
                    if (!mem_busy) begin
                        write_q <= 1'b1;
                        state_q <= StGap;
                    end
                end

                StGap: begin
                    // The strobe is visible during this cycle with the old
                    // address, so the increment lands after the write.
                    addr_q  <= addr_q + 22'd1;
                    state_q <= (byte_idx_q == 3'd4) ? StFetch : StByte;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bridge_ready          = downloading_q & ~fifo_full;
    assign downloading           = downloading_q;
    assign loader_busy           = ~fifo_empty | (state_q == StByte) |
                                   (state_q == StWrite) | (state_q == StGap);
    assign loader_addr_mem       = addr_q;
    assign loader_write_mem      = write_q;
    assign loader_write_data_mem = wdata_q;
    assign header                = header_q;
    assign header_valid          = header_valid_q;
    assign overrun               = overrun_q;

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed bench for nes_rom_loader: basic load, busy stall, backpressure,
// bad magic, restart and asynchronous reset.

module tb_nes_rom_loader;

    logic         clk_85_9 = 1'b0;
    logic         reset_n  = 1'b1;
    logic         dl_start = 1'b0;
    logic         dl_end   = 1'b0;
    logic         bridge_wr = 1'b0;
    logic [31:0]  bridge_data = '0;
    logic         mem_busy = 1'b0;
    logic         bridge_ready;
    logic         downloading;
    logic         loader_busy;
    logic [21:0]  loader_addr_mem;
    logic         loader_write_mem;
    logic [7:0]   loader_write_data_mem;
    logic [127:0] header;
    logic         header_valid;
    logic         overrun;

    nes_rom_loader #(
        .FIFO_DEPTH   (4),
        .STRIP_HEADER (1)
    ) dut (
        .clk_85_9              (clk_85_9),
        .reset_n               (reset_n),
        .dl_start              (dl_start),
        .dl_end                (dl_end),
        .bridge_wr             (bridge_wr),
        .bridge_data           (bridge_data),
        .bridge_ready          (bridge_ready),
        .mem_busy              (mem_busy),
        .downloading           (downloading),
        .loader_busy           (loader_busy),
        .loader_addr_mem       (loader_addr_mem),
        .loader_write_mem      (loader_write_mem),
        .loader_write_data_mem (loader_write_data_mem),
        .header                (header),
        .header_valid          (header_valid),
        .overrun               (overrun)
    );

    always #5 clk_85_9 = ~clk_85_9;

    int n_checks = 0;
    int n_pass   = 0;
    int b2b      = 0;
    logic prev_wr = 1'b0;
    logic [29:0] wq[$];   // {addr, data} of every strobe seen

    always @(negedge clk_85_9) begin
        if (loader_write_mem) begin
            wq.push_back({loader_addr_mem, loader_write_data_mem});
            if (prev_wr) b2b++;
        end
        prev_wr = loader_write_mem;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_85_9);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bridge_wr   = 1'b1;
        bridge_data = w;
        tick();
        bridge_wr   = 1'b0;
    endtask

    task automatic pulse_start();
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
    endtask

    task automatic pulse_end();
        dl_end = 1'b1;
        tick();
        dl_end = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while (wq.size() < n && k < 400) begin
            tick();
            k++;
        end
        chk(tag, wq.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (downloading && k < 400) begin
            tick();
            k++;
        end
        chk(tag, downloading, 1'b0);
    endtask

    task automatic chk_wr(input int i, input logic [21:0] a, input logic [7:0] d,
                          input string tag);
        logic [29:0] got;
        got = (i < wq.size()) ? wq[i] : 30'bx;
        chk(tag, got, {a, d});
    endtask

    task automatic push_magic_header(input logic [31:0] w1);
        push(32'h4E45531A);
        push(w1);
        push(32'h0);
        push(32'h0);
    endtask

    initial begin
        int base;
        logic [31:0] bp_words [5];
        logic [31:0] w;
        logic [7:0]  d;

        bp_words[0] = 32'h11223344;
        bp_words[1] = 32'h55667788;
        bp_words[2] = 32'h99AABBCC;
        bp_words[3] = 32'hDDEEFF00;
        bp_words[4] = 32'h01020304;

        // ---------------- reset state
        #2 reset_n = 1'b0;
        #2;
        chk("rst_downloading", downloading, 1'b0);
        chk("rst_loader_busy", loader_busy, 1'b0);
        chk("rst_write", loader_write_mem, 1'b0);
        chk("rst_addr", loader_addr_mem, 22'd0);
        chk("rst_header", header, 128'd0);
        chk("rst_header_valid", header_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_bridge_ready", bridge_ready, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // word outside a session is ignored
        push(32'h4E45531A);
        tick();
        chk("idle_push_ignored", loader_busy, 1'b0);

        // ---------------- basic load
        base = wq.size();
        pulse_start();
        chk("t1_downloading", downloading, 1'b1);
        chk("t1_ready", bridge_ready, 1'b1);
        push_magic_header(32'h02010000);
        push(32'hAABBCCDD);
        pulse_end();
        wait_writes(base + 4, "t1_nwrites");
        chk_wr(base + 0, 22'd0, 8'hAA, "t1_wr0");
        chk_wr(base + 1, 22'd1, 8'hBB, "t1_wr1");
        chk_wr(base + 2, 22'd2, 8'hCC, "t1_wr2");
        chk_wr(base + 3, 22'd3, 8'hDD, "t1_wr3");
        wait_idle("t1_idle");
        chk("t1_header_valid", header_valid, 1'b1);
        chk("t1_header_b4", header[39:32], 8'h02);
        chk("t1_header", header, {80'h0, 16'h0102, 32'h1A53454E});
        chk("t1_overrun", overrun, 1'b0);
        chk("t1_loader_busy", loader_busy, 1'b0);
        chk("t1_total_writes", wq.size(), base + 4);

        // ---------------- busy stall
        base = wq.size();
        mem_busy = 1'b1;
        pulse_start();
        push_magic_header(32'h0);
        push(32'hAABBCCDD);
        repeat (30) tick();
        chk("t2_no_write", wq.size(), base);
        chk("t2_addr_a", loader_addr_mem, 22'd0);
        chk("t2_data_a", loader_write_data_mem, 8'hAA);
        chk("t2_busy", loader_busy, 1'b1);
        repeat (10) tick();
        chk("t2_no_write_b", wq.size(), base);
        chk("t2_addr_b", loader_addr_mem, 22'd0);
        chk("t2_data_b", loader_write_data_mem, 8'hAA);
        mem_busy = 1'b0;
        tick();
        chk("t2_strobe", loader_write_mem, 1'b1);
        chk("t2_strobe_addr", loader_addr_mem, 22'd0);
        chk("t2_strobe_data", loader_write_data_mem, 8'hAA);
        tick();
        chk("t2_strobe_one_cycle", loader_write_mem, 1'b0);
        pulse_end();
        wait_writes(base + 4, "t2_nwrites");
        chk_wr(base + 0, 22'd0, 8'hAA, "t2_wr0");
        chk_wr(base + 3, 22'd3, 8'hDD, "t2_wr3");
        wait_idle("t2_idle");

        // ---------------- backpressure
        base = wq.size();
        pulse_start();
        push_magic_header(32'h0);
        repeat (30) tick();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(bp_words[i]);
        chk("t3_ready_low", bridge_ready, 1'b0);
        chk("t3_no_overrun_yet", overrun, 1'b0);
        push(32'h05060708);
        chk("t3_overrun", overrun, 1'b1);
        mem_busy = 1'b0;
        pulse_end();
        wait_writes(base + 20, "t3_nwrites");
        for (int i = 0; i < 20; i++) begin
            w = bp_words[i / 4];
            d = w[31 - 8 * (i % 4) -: 8];
            chk_wr(base + i, 22'(i), d, $sformatf("t3_wr%0d", i));
        end
        wait_idle("t3_idle");
        chk("t3_overrun_sticky", overrun, 1'b1);
        chk("t3_total_writes", wq.size(), base + 20);

        // ---------------- bad magic, word alongside dl_start dropped
        base = wq.size();
        dl_start    = 1'b1;
        bridge_wr   = 1'b1;
        bridge_data = 32'hFFFFFFFF;
        tick();
        dl_start  = 1'b0;
        bridge_wr = 1'b0;
        chk("t4_start_word_dropped", loader_busy, 1'b0);
        chk("t4_overrun_cleared", overrun, 1'b0);
        push(32'h0);
        push(32'h0);
        push(32'h0);
        push(32'h0);
        push(32'hA1B2C3D4);
        pulse_end();
        wait_writes(base + 4, "t4_nwrites");
        chk_wr(base + 0, 22'd0, 8'hA1, "t4_wr0");
        chk_wr(base + 3, 22'd3, 8'hD4, "t4_wr3");
        wait_idle("t4_idle");
        chk("t4_header_valid", header_valid, 1'b0);

        // ---------------- restart mid-payload
        base = wq.size();
        pulse_start();
        push_magic_header(32'h0);
        repeat (25) tick();
        push(32'h11223344);
        push(32'h55667788);
        wait_writes(base + 3, "t5_three_writes");
        dl_start = 1'b1;
        tick();
        dl_start = 1'b0;
        chk("t5_no_strobe", loader_write_mem, 1'b0);
        chk("t5_addr", loader_addr_mem, 22'd0);
        chk("t5_header", header, 128'd0);
        chk("t5_header_valid", header_valid, 1'b0);
        chk("t5_loader_busy", loader_busy, 1'b0);
        tick();
        chk("t5_no_strobe_b", loader_write_mem, 1'b0);
        chk("t5_writes_stopped", wq.size(), base + 3);
        push_magic_header(32'h0);
        push(32'hDEADBEEF);
        pulse_end();
        wait_writes(base + 7, "t5_nwrites");
        chk_wr(base + 3, 22'd0, 8'hDE, "t5_new_wr0");
        chk_wr(base + 6, 22'd3, 8'hEF, "t5_new_wr3");
        wait_idle("t5_idle");
        chk("t5_total_writes", wq.size(), base + 7);
        chk("t5_header_valid_new", header_valid, 1'b1);

        // ---------------- asynchronous reset while stalled in WRITE
        base = wq.size();
        pulse_start();
        push_magic_header(32'h0);
        repeat (25) tick();
        push(32'h11223344);
        push(32'h55667788);
        wait_writes(base + 5, "t6_five_writes");
        mem_busy = 1'b1;
        repeat (6) tick();
        chk("t6_stalled", wq.size(), base + 5);
        chk("t6_addr", loader_addr_mem, 22'd5);
        chk("t6_data", loader_write_data_mem, 8'h66);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_downloading", downloading, 1'b0);
        chk("t6_rst_busy", loader_busy, 1'b0);
        chk("t6_rst_write", loader_write_mem, 1'b0);
        chk("t6_rst_addr", loader_addr_mem, 22'd0);
        chk("t6_rst_data", loader_write_data_mem, 8'd0);
        chk("t6_rst_header", header, 128'd0);
        chk("t6_rst_header_valid", header_valid, 1'b0);
        chk("t6_rst_ready", bridge_ready, 1'b0);
        tick();
        tick();
        reset_n  = 1'b1;
        mem_busy = 1'b0;
        repeat (20) tick();
        chk("t6_no_strobe_after", wq.size(), base + 5);
        chk("t6_idle_after", downloading, 1'b0);

        chk("no_back_to_back_strobes", b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
